matcher_req_arbiter: RTL and testbench

- Shares one key/data stream matcher between NREQ requesters.
- Round-robin grant, one op per cycle to the matcher.
- Tracks outstanding ops in an ID FIFO and routes in-order matcher responses back to the issuing requester.
- Sequences a flush: stop issue, drain outstanding ops, pulse matcher clear, acknowledge.

---
 rtl/matcher_req_arbiter.sv | 282 ++++++++++++++++++++++++++++
 tb/tb_matcher_req_arbiter.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/matcher_req_arbiter.sv
// ---------------------------------------------------------------------------
// matcher_req_arbiter
//
// Shares a single key/data stream matcher between NREQ requesters.
//   - Round-robin arbitration, at most one op per cycle forwarded to the
//     matcher. A winner presented while the matcher stalls stays locked
//     until it is accepted, so m_valid/m_key/m_data never change under a stall.
//   - Every accepted op pushes its requester ID into an ID FIFO. The matcher
//     answers in issue order, so each response pops the FIFO head and is
//     routed (registered, one cycle later) to that requester.
//   - Flush sequencing: RUN -> DRAIN (no new grants, wait for all
//     outstanding ops to return) -> CLEAR (one-cycle m_clear pulse)
//     -> DONE (one-cycle flush_done pulse) -> RUN with the rr pointer at 0.
//
// Optional feature (compile-time macro MATCH_ARB_STATS_EN):
//   defined   : stat_hits / stat_miss count routed responses by hit flag,
//               saturate at all-ones, and clear on rst and in CLEAR.
//   undefined : stat_hits / stat_miss are tied to zero.
//
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   req_valid/op/key/data  per-requester op inputs (keys/data packed,
//                    requester i at [i*W +: W]); req_ready one-hot accept
//   m_valid/ready/op/key/data  op channel to the matcher
//   m_clear          one-cycle matcher clear pulse during a flush
//   m_rsp_valid/hit/data  in-order matcher responses
//   rsp_valid        one-hot routed response strobe, rsp_hit/rsp_data payload
//   flush_req        level flush request, sampled only in RUN
//   flush_done       one-cycle flush acknowledge
//   outs_cnt         number of ops issued but not yet answered
//   stat_hits/miss   response statistics (optional feature)
// ---------------------------------------------------------------------------
module matcher_req_arbiter #(
    parameter int NREQ     = 4,
    parameter int KWIDTH   = 16,
    parameter int DWIDTH   = 16,
    parameter int MAX_OUTS = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NREQ-1:0]            req_valid,
    output logic [NREQ-1:0]            req_ready,
    input  logic [NREQ-1:0]            req_op,
    input  logic [NREQ*KWIDTH-1:0]     req_key,
    input  logic [NREQ*DWIDTH-1:0]     req_data,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic                       m_op,
    output logic [KWIDTH-1:0]          m_key,
    output logic [DWIDTH-1:0]          m_data,
    output logic                       m_clear,
    input  logic                       m_rsp_valid,
    input  logic                       m_rsp_hit,
    input  logic [DWIDTH-1:0]          m_rsp_data,
    output logic [NREQ-1:0]            rsp_valid,
    output logic                       rsp_hit,
    output logic [DWIDTH-1:0]          rsp_data,
    input  logic                       flush_req,
    output logic                       flush_done,
    output logic [$clog2(MAX_OUTS):0]  outs_cnt,
    output logic [31:0]                stat_hits,
    output logic [31:0]                stat_miss
);

    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int PW  = $clog2(MAX_OUTS);
    localparam int CW  = PW + 1;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_CLEAR = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t           state;
    logic [IDW-1:0]   rr_ptr;
    logic             lock;
    logic [IDW-1:0]   lock_id;

    logic [NREQ-1:0]  eligible;
    logic             rr_found;
    logic [IDW-1:0]   rr_pick;
    logic             win_valid;
    logic [IDW-1:0]   win_id;
    int               win_idx;
    logic             xfer;

    logic [IDW-1:0]   fifo_mem [MAX_OUTS];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    cnt_nxt;
    logic [IDW-1:0]   head_id;
    logic             push;
    logic             pop;
    logic             err_q;

    function automatic logic [NREQ-1:0] onehot(input logic [IDW-1:0] id);
        logic [NREQ-1:0] v;
        v     = '0;
        v[id] = 1'b1;
        return v;
    endfunction

    // New grants only in RUN with FIFO room. A pending flush request also
    // blocks fresh arbitration so the FSM can move to DRAIN; a locked
    // (stalled) winner is still allowed to finish.
    always_comb begin
        eligible = '0;
        if (state == ST_RUN && cnt < CW'(MAX_OUTS) && !flush_req) begin
            eligible = req_valid;
        end
    end

    // Rotating priority search starting at rr_ptr.
    always_comb begin
        int idx;
        idx      = 0;
        rr_found = 1'b0;
        rr_pick  = '0;
        for (int i = 0; i < NREQ; i++) begin
            idx = (int'(rr_ptr) + i) % NREQ;
            if (!rr_found && eligible[idx]) begin
                rr_found = 1'b1;
                rr_pick  = IDW'(idx);
            end
        end
    end

    // A locked winner bypasses arbitration until the matcher accepts it.
    always_comb begin
        if (lock) begin
            win_id    = lock_id;
            win_valid = req_valid[lock_id];
        end else begin
            win_id    = rr_pick;
            win_valid = rr_found;
        end
        if (rst || state != ST_RUN) begin
            win_valid = 1'b0;
        end
        win_idx = int'(win_id);
    end

    assign m_valid   = win_valid;
    assign m_op      = req_op[win_id];
    assign m_key     = req_key[win_idx*KWIDTH +: KWIDTH];
    assign m_data    = req_data[win_idx*DWIDTH +: DWIDTH];
    assign xfer      = m_valid && m_ready;
    assign req_ready = xfer ? onehot(win_id) : '0;

    assign push    = xfer;
    // A response with nothing outstanding has no owner and is dropped.
    assign pop     = m_rsp_valid && (cnt != '0);
    assign head_id = fifo_mem[rd_ptr];

    always_comb begin
        case ({push, pop})
            2'b10:   cnt_nxt = cnt + CW'(1);
            2'b01:   cnt_nxt = cnt - CW'(1);
            default: cnt_nxt = cnt;
        endcase
    end

    assign outs_cnt = cnt;

    // ID FIFO storage; contents are meaningless outside [rd_ptr, wr_ptr).
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= win_id;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            err_q  <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            cnt   <= cnt_nxt;
            err_q <= err_q | (m_rsp_valid && cnt == '0);
        end
    end

    // Response routing: one cycle after the matcher answers.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid <= '0;
            rsp_hit   <= 1'b0;
            rsp_data  <= '0;
        end else begin
            rsp_valid <= pop ? onehot(head_id) : '0;
            if (pop) begin
                rsp_hit  <= m_rsp_hit;
                rsp_data <= m_rsp_data;
            end
        end
    end

    // Flush FSM with registered pulse outputs, round-robin pointer and
    // stall lock. DRAIN looks at the post-update count so m_clear follows
    // the last response by exactly one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_RUN;
            rr_ptr     <= '0;
            lock       <= 1'b0;
            lock_id    <= '0;
            m_clear    <= 1'b0;
            flush_done <= 1'b0;
        end else begin
            m_clear    <= 1'b0;
            flush_done <= 1'b0;
            lock       <= m_valid && !m_ready;
            lock_id    <= win_id;
            if (xfer) begin
                rr_ptr <= (win_id == IDW'(NREQ - 1)) ? '0 : win_id + IDW'(1);
            end
            case (state)
                ST_RUN: begin
                    if (flush_req && !(m_valid && !m_ready)) begin
                        state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (cnt_nxt == '0) begin
                        state   <= ST_CLEAR;
                        m_clear <= 1'b1;
                    end
                end
                ST_CLEAR: begin
                    state      <= ST_DONE;
                    flush_done <= 1'b1;
                end
                ST_DONE: begin
                    state  <= ST_RUN;
                    rr_ptr <= '0;
                end
                default: begin
                    state <= ST_RUN;
                end
            endcase
        end
    end

`ifdef MATCH_ARB_STATS_EN
    logic [31:0] hits_q;
    logic [31:0] miss_q;

    always_ff @(posedge clk) begin
        if (rst || state == ST_CLEAR) begin
            hits_q <= '0;
            miss_q <= '0;
        end else if (pop) begin
            if (m_rsp_hit) begin
                if (hits_q != 32'hFFFF_FFFF) begin
                    hits_q <= hits_q + 32'd1;
                end
            end else begin
                if (miss_q != 32'hFFFF_FFFF) begin
                    miss_q <= miss_q + 32'd1;
                end
            end
        end
    end

    assign stat_hits = hits_q;
    assign stat_miss = miss_q;
`else
    assign stat_hits = '0;
    assign stat_miss = '0;
`endif

endmodule

// File: tb/tb_matcher_req_arbiter.sv
// ---------------------------------------------------------------------------
// tb_matcher_req_arbiter
//
// Directed bench for matcher_req_arbiter (NREQ=4, KWIDTH=DWIDTH=16,
// MAX_OUTS=8). Requester i presents key 16'hA000+i, data 16'hD000+i and
// op i[0]. A table of per-cycle vectors covers round-robin order, stalls,
// grant locking and simultaneous issue/response; hand-written sequences
// cover the outstanding limit, flush sequencing, statistics, reset in
// DRAIN and a response with nothing outstanding.
// ---------------------------------------------------------------------------
module tb_matcher_req_arbiter;

    localparam int NREQ     = 4;
    localparam int KWIDTH   = 16;
    localparam int DWIDTH   = 16;
    localparam int MAX_OUTS = 8;

    logic                  clk;
    logic                  rst;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ-1:0]       req_op;
    logic [NREQ*KWIDTH-1:0] req_key;
    logic [NREQ*DWIDTH-1:0] req_data;
    logic                  m_valid;
    logic                  m_ready;
    logic                  m_op;
    logic [KWIDTH-1:0]     m_key;
    logic [DWIDTH-1:0]     m_data;
    logic                  m_clear;
    logic                  m_rsp_valid;
    logic                  m_rsp_hit;
    logic [DWIDTH-1:0]     m_rsp_data;
    logic [NREQ-1:0]       rsp_valid;
    logic                  rsp_hit;
    logic [DWIDTH-1:0]     rsp_data;
    logic                  flush_req;
    logic                  flush_done;
    logic [$clog2(MAX_OUTS):0] outs_cnt;
    logic [31:0]           stat_hits;
    logic [31:0]           stat_miss;

    int passed = 0;
    int total  = 0;

    matcher_req_arbiter #(
        .NREQ(NREQ), .KWIDTH(KWIDTH), .DWIDTH(DWIDTH), .MAX_OUTS(MAX_OUTS)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_key(req_key), .req_data(req_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_op(m_op),
        .m_key(m_key), .m_data(m_data), .m_clear(m_clear),
        .m_rsp_valid(m_rsp_valid), .m_rsp_hit(m_rsp_hit), .m_rsp_data(m_rsp_data),
        .rsp_valid(rsp_valid), .rsp_hit(rsp_hit), .rsp_data(rsp_data),
        .flush_req(flush_req), .flush_done(flush_done), .outs_cnt(outs_cnt),
        .stat_hits(stat_hits), .stat_miss(stat_miss)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  rv;     // req_valid
        logic        mr;     // m_ready
        logic        rspv;   // m_rsp_valid
        logic [15:0] rdata;  // m_rsp_data, hit flag = rdata[0]
        int          win;    // expected winner, -1 = no m_valid
        logic [3:0]  ready;  // expected req_ready
        logic [3:0]  rspo;   // expected rsp_valid
        logic [15:0] rdo;    // expected rsp_data when rspo != 0
        int          cnt;    // expected outs_cnt
    } vec_t;

    vec_t vq[$];

    task automatic addVec(input logic [3:0] rv, input logic mr, input logic rspv,
                          input logic [15:0] rdata, input int win, input logic [3:0] ready,
                          input logic [3:0] rspo, input logic [15:0] rdo, input int cnt);
        vec_t v;
        v.rv = rv; v.mr = mr; v.rspv = rspv; v.rdata = rdata; v.win = win;
        v.ready = ready; v.rspo = rspo; v.rdo = rdo; v.cnt = cnt;
        vq.push_back(v);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [3:0] rv, input logic mr, input logic rspv,
                                 input logic [15:0] rdata, input logic flush);
        req_valid   = rv;
        m_ready     = mr;
        m_rsp_valid = rspv;
        m_rsp_data  = rdata;
        m_rsp_hit   = rdata[0];
        flush_req   = flush;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end else begin
            passed++;
        end
    endtask

    task automatic checkWinner(input string name, input int w);
        logic [15:0] kexp;
        logic [15:0] dexp;
        kexp = 16'hA000 + 16'(w);
        dexp = 16'hD000 + 16'(w);
        checkOutput({name, "_m_key"}, 32'(m_key), 32'(kexp));
        checkOutput({name, "_m_data"}, 32'(m_data), 32'(dexp));
        checkOutput({name, "_m_op"}, 32'(m_op), 32'(w % 2));
    endtask

    initial begin
        logic [3:0] one;
        one = 4'b0001;

        for (int i = 0; i < NREQ; i++) begin
            req_key[i*KWIDTH +: KWIDTH]  = 16'hA000 + 16'(i);
            req_data[i*DWIDTH +: DWIDTH] = 16'hD000 + 16'(i);
        end
        req_op = 4'b1010;
        rst = 1'b1;
        applyStimulus(4'h0, 1'b0, 1'b0, 16'h0, 1'b0);

        // Reset state.
        tick();
        tick();
        checkOutput("rst_req_ready", 32'(req_ready), 0);
        checkOutput("rst_m_valid", 32'(m_valid), 0);
        checkOutput("rst_m_clear", 32'(m_clear), 0);
        checkOutput("rst_rsp_valid", 32'(rsp_valid), 0);
        checkOutput("rst_flush_done", 32'(flush_done), 0);
        checkOutput("rst_outs_cnt", 32'(outs_cnt), 0);
        checkOutput("rst_stat_hits", stat_hits, 0);
        checkOutput("rst_stat_miss", stat_miss, 0);
        rst = 1'b0;

        // Round robin with responses two cycles after issue.
        addVec(4'hF, 1, 0, 16'h0000,  0, 4'b0001, 4'b0000, 16'h0000, 0);
        addVec(4'hF, 1, 0, 16'h0000,  1, 4'b0010, 4'b0000, 16'h0000, 1);
        addVec(4'hF, 1, 1, 16'h1000,  2, 4'b0100, 4'b0000, 16'h0000, 2);
        addVec(4'hF, 1, 1, 16'h1001,  3, 4'b1000, 4'b0001, 16'h1000, 2);
        addVec(4'hF, 1, 1, 16'h1002,  0, 4'b0001, 4'b0010, 16'h1001, 2);
        addVec(4'hF, 1, 1, 16'h1003,  1, 4'b0010, 4'b0100, 16'h1002, 2);
        addVec(4'h0, 1, 1, 16'h1004, -1, 4'b0000, 4'b1000, 16'h1003, 2);
        addVec(4'h0, 1, 1, 16'h1005, -1, 4'b0000, 4'b0001, 16'h1004, 1);
        addVec(4'h0, 1, 0, 16'h0000, -1, 4'b0000, 4'b0010, 16'h1005, 0);
        // Backpressure on requester 2, then grant locking across a stall.
        addVec(4'h4, 0, 0, 16'h0000,  2, 4'b0000, 4'b0000, 16'h0000, 0);
        addVec(4'h4, 0, 0, 16'h0000,  2, 4'b0000, 4'b0000, 16'h0000, 0);
        addVec(4'h4, 0, 0, 16'h0000,  2, 4'b0000, 4'b0000, 16'h0000, 0);
        addVec(4'h4, 1, 0, 16'h0000,  2, 4'b0100, 4'b0000, 16'h0000, 0);
        addVec(4'h0, 1, 0, 16'h0000, -1, 4'b0000, 4'b0000, 16'h0000, 1);
        addVec(4'h1, 0, 0, 16'h0000,  0, 4'b0000, 4'b0000, 16'h0000, 1);
        addVec(4'h9, 0, 0, 16'h0000,  0, 4'b0000, 4'b0000, 16'h0000, 1);
        addVec(4'h9, 1, 0, 16'h0000,  0, 4'b0001, 4'b0000, 16'h0000, 1);
        addVec(4'h8, 1, 0, 16'h0000,  3, 4'b1000, 4'b0000, 16'h0000, 2);
        addVec(4'h0, 1, 1, 16'h2000, -1, 4'b0000, 4'b0000, 16'h0000, 3);
        addVec(4'h0, 1, 1, 16'h2001, -1, 4'b0000, 4'b0100, 16'h2000, 2);
        addVec(4'h0, 1, 1, 16'h2002, -1, 4'b0000, 4'b0001, 16'h2001, 1);
        addVec(4'h0, 1, 0, 16'h0000, -1, 4'b0000, 4'b1000, 16'h2002, 0);
        // Simultaneous issue and response.
        addVec(4'h2, 1, 0, 16'h0000,  1, 4'b0010, 4'b0000, 16'h0000, 0);
        addVec(4'h4, 1, 1, 16'h3000,  2, 4'b0100, 4'b0000, 16'h0000, 1);
        addVec(4'h0, 1, 1, 16'h3001, -1, 4'b0000, 4'b0010, 16'h3000, 1);
        addVec(4'h0, 1, 0, 16'h0000, -1, 4'b0000, 4'b0100, 16'h3001, 0);

        foreach (vq[i]) begin
            applyStimulus(vq[i].rv, vq[i].mr, vq[i].rspv, vq[i].rdata, 1'b0);
            #1;
            checkOutput($sformatf("row%0d_m_valid", i), 32'(m_valid), 32'(vq[i].win >= 0));
            if (vq[i].win >= 0) begin
                checkWinner($sformatf("row%0d", i), vq[i].win);
            end
            checkOutput($sformatf("row%0d_req_ready", i), 32'(req_ready), 32'(vq[i].ready));
            checkOutput($sformatf("row%0d_rsp_valid", i), 32'(rsp_valid), 32'(vq[i].rspo));
            if (vq[i].rspo != 4'b0000) begin
                checkOutput($sformatf("row%0d_rsp_data", i), 32'(rsp_data), 32'(vq[i].rdo));
                checkOutput($sformatf("row%0d_rsp_hit", i), 32'(rsp_hit), 32'(vq[i].rdo[0]));
            end
            checkOutput($sformatf("row%0d_outs_cnt", i), 32'(outs_cnt), vq[i].cnt);
            tick();
        end

        // Outstanding limit: rr is at 3, eight grants fill the FIFO.
        applyStimulus(4'hF, 1'b1, 1'b0, 16'h0, 1'b0);
        for (int k = 0; k < 8; k++) begin
            #1;
            checkOutput($sformatf("limit_grant%0d", k), 32'(req_ready), 32'(one << ((3 + k) % 4)));
            tick();
        end
        #1;
        checkOutput("limit_outs_full", 32'(outs_cnt), 8);
        checkOutput("limit_no_valid", 32'(m_valid), 0);
        checkOutput("limit_no_ready", 32'(req_ready), 0);
        tick();
        applyStimulus(4'hF, 1'b1, 1'b1, 16'h4100, 1'b0);
        #1;
        checkOutput("limit_no_valid_on_rsp", 32'(m_valid), 0);
        tick();
        applyStimulus(4'hF, 1'b1, 1'b0, 16'h0, 1'b0);
        #1;
        checkOutput("limit_outs_after_rsp", 32'(outs_cnt), 7);
        checkOutput("limit_regrant", 32'(req_ready), 32'(4'b1000));
        checkOutput("limit_first_rsp", 32'(rsp_valid), 32'(4'b1000));
        tick();
        for (int k = 0; k < 8; k++) begin
            applyStimulus(4'h0, 1'b1, 1'b1, 16'h4000 + 16'(k), 1'b0);
            #1;
            if (k > 0) begin
                checkOutput($sformatf("limit_drain_rsp%0d", k - 1), 32'(rsp_valid),
                            32'(one << ((k - 1) % 4)));
                checkOutput($sformatf("limit_drain_data%0d", k - 1), 32'(rsp_data),
                            32'(16'h4000 + 16'(k - 1)));
            end
            tick();
        end
        applyStimulus(4'h0, 1'b1, 1'b0, 16'h0, 1'b0);
        #1;
        checkOutput("limit_drain_rsp7", 32'(rsp_valid), 32'(4'b1000));
        checkOutput("limit_drain_empty", 32'(outs_cnt), 0);
        tick();

        // Flush with three outstanding ops.
        applyStimulus(4'h7, 1'b1, 1'b0, 16'h0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            #1;
            checkOutput($sformatf("flush_issue%0d", k), 32'(req_ready), 32'(one << k));
            tick();
        end
        applyStimulus(4'hF, 1'b1, 1'b0, 16'h0, 1'b1);
        #1;
        checkOutput("flush_no_grant_run", 32'(m_valid), 0);
        tick();
        for (int k = 0; k < 3; k++) begin
            applyStimulus(4'hF, 1'b1, 1'b1, 16'h5000 + 16'(k), 1'b0);
            #1;
            checkOutput($sformatf("flush_drain_no_grant%0d", k), 32'(m_valid), 0);
            checkOutput($sformatf("flush_drain_no_clear%0d", k), 32'(m_clear), 0);
            tick();
        end
        applyStimulus(4'hF, 1'b1, 1'b0, 16'h0, 1'b0);
        #1;
        checkOutput("flush_m_clear", 32'(m_clear), 1);
        checkOutput("flush_clear_no_done", 32'(flush_done), 0);
        checkOutput("flush_clear_no_grant", 32'(m_valid), 0);
        checkOutput("flush_last_rsp", 32'(rsp_valid), 32'(4'b0100));
        tick();
        #1;
        checkOutput("flush_done_pulse", 32'(flush_done), 1);
        checkOutput("flush_clear_single", 32'(m_clear), 0);
        checkOutput("flush_done_no_grant", 32'(m_valid), 0);
        tick();
        applyStimulus(4'hF, 1'b0, 1'b0, 16'h0, 1'b0);
        #1;
        checkOutput("flush_done_single", 32'(flush_done), 0);
        checkOutput("flush_next_valid", 32'(m_valid), 1);
        checkWinner("flush_next", 0);
        checkOutput("flush_next_stall", 32'(req_ready), 0);
        tick();

        // Statistics: five responses with hit pattern 1,0,1,1,0.
        applyStimulus(4'h1, 1'b1, 1'b0, 16'h0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            #1;
            checkOutput($sformatf("stats_issue%0d", k), 32'(req_ready), 32'(4'b0001));
            tick();
        end
        begin
            logic [4:0] pat;
            pat = 5'b01101;
            for (int k = 0; k < 5; k++) begin
                applyStimulus(4'h0, 1'b1, 1'b1, 16'h6000 + 16'(pat[k]), 1'b0);
                #1;
                if (k > 0) begin
                    checkOutput($sformatf("stats_rsp_hit%0d", k - 1), 32'(rsp_hit), 32'(pat[k-1]));
                end
                tick();
            end
            applyStimulus(4'h0, 1'b1, 1'b0, 16'h0, 1'b0);
            #1;
            checkOutput("stats_rsp_hit4", 32'(rsp_hit), 32'(pat[4]));
            checkOutput("stats_rsp_valid4", 32'(rsp_valid), 32'(4'b0001));
            tick();
        end
        #1;
`ifdef MATCH_ARB_STATS_EN
        checkOutput("stats_hits", stat_hits, 3);
        checkOutput("stats_miss", stat_miss, 2);
`else
        checkOutput("stats_hits_off", stat_hits, 0);
        checkOutput("stats_miss_off", stat_miss, 0);
`endif
        applyStimulus(4'h0, 1'b1, 1'b0, 16'h0, 1'b1);
        tick();
        applyStimulus(4'h0, 1'b1, 1'b0, 16'h0, 1'b0);
        tick();
        #1;
        checkOutput("stats_flush_clear", 32'(m_clear), 1);
        tick();
        #1;
        checkOutput("stats_flush_done", 32'(flush_done), 1);
        checkOutput("stats_hits_cleared", stat_hits, 0);
        checkOutput("stats_miss_cleared", stat_miss, 0);
        tick();

        // Reset while draining.
        applyStimulus(4'h3, 1'b1, 1'b0, 16'h0, 1'b0);
        tick();
        tick();
        applyStimulus(4'h0, 1'b1, 1'b0, 16'h0, 1'b1);
        tick();
        applyStimulus(4'h0, 1'b1, 1'b0, 16'h0, 1'b0);
        #1;
        checkOutput("rstdrain_outs_before", 32'(outs_cnt), 2);
        tick();
        rst = 1'b1;
        applyStimulus(4'hF, 1'b0, 1'b0, 16'h0, 1'b0);
        tick();
        rst = 1'b0;
        #1;
        checkOutput("rstdrain_outs_cnt", 32'(outs_cnt), 0);
        checkOutput("rstdrain_m_clear", 32'(m_clear), 0);
        checkOutput("rstdrain_flush_done", 32'(flush_done), 0);
        checkOutput("rstdrain_run_valid", 32'(m_valid), 1);
        checkWinner("rstdrain_rr0", 0);
        tick();

        // Late response with nothing outstanding.
        applyStimulus(4'h0, 1'b0, 1'b1, 16'h7001, 1'b0);
        tick();
        applyStimulus(4'h0, 1'b0, 1'b0, 16'h0, 1'b0);
        #1;
        checkOutput("orphan_no_rsp", 32'(rsp_valid), 0);
        checkOutput("orphan_outs_cnt", 32'(outs_cnt), 0);
        checkOutput("orphan_err_sticky", 32'(dut.err_q), 1);
        tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
